ign_scheduler: RTL
==================

IGN_SCHEDULER -- requirements
Module: ign_scheduler

Interface
REQ-001 Parameter N_CH, 4, number of ignition channels.
REQ-002 Parameter ANGLE_W, 12, width of the crank angle in counts (720 deg cycle).
REQ-003 Parameter ANGLE_MAX, 2880, counts per engine cycle (0.25 deg/count); angle wraps ANGLE_MAX-1 -> 0.
REQ-004 Parameter MAX_DWELL_CYC, 20000, dwell timeout in clk cycles (10 ms at 2 MHz).
REQ-005 The module SHALL have these ports (clock and reset first):
- clk  in  1  EFI clock; one clock domain; all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- synced  in  1  decoder has crank/cam sync.
- angle  in  ANGLE_W  current engine angle in counts.
- angle_valid  in  1  one-cycle pulse when angle takes a new value.
- cfg_we  in  1  shadow register write strobe.
- cfg_addr  in  3  {channel[1:0], sel}; sel 0 = dwell angle, 1 = fire angle.
- cfg_data  in  ANGLE_W  write data.
- cfg_commit  in  1  request shadow-to-active copy.
- ign  out  N_CH  coil drive; 1 = dwelling.
- fault  out  N_CH  sticky dwell-timeout flag per channel.
- commit_pending  out  1  commit requested, not yet applied.

Function
REQ-006 Each channel SHALL run a state machine with states IDLE, DWELL, LOCKOUT.
REQ-007 IDLE->DWELL on a cycle with synced=1, angle_valid=1 and angle==active dwell angle; on entry the active fire angle SHALL be latched per channel.
REQ-008 DWELL->IDLE on angle_valid=1 with angle==latched fire angle; this falling edge is the spark.
REQ-009 ign[ch] SHALL be registered: 1 exactly in DWELL, changing one cycle after the qualifying angle_valid cycle.
REQ-010 A channel whose active dwell angle equals its fire angle SHALL never leave IDLE.
REQ-011 cfg_we SHALL write the shadow register selected by cfg_addr in the same cycle; shadow writes SHALL never affect active values directly.
REQ-012 cfg_commit SHALL set commit_pending; active <= shadow for all channels SHALL occur on the cycle angle_valid=1 and angle==0, which SHALL clear commit_pending.
REQ-013 A channel in DWELL across a commit SHALL keep its latched fire angle.
REQ-014 cfg_commit and the angle==0 update in the same cycle: commit_pending stays set; the copy occurs at the next wrap.
REQ-015 synced=0 SHALL force every channel to IDLE and ign to 0 on the next cycle, overriding all other transitions; fault is unaffected.
REQ-016 Angle matching SHALL be exact equality; skipped angle values do not trigger (decoder guarantees every count is presented).
REQ-017 Simultaneous dwell match on several channels SHALL all be honoured in the same cycle; no arbitration between channels.

Reset
REQ-018 On rst=1: all channels IDLE, ign=0, fault=0, commit_pending=0, shadow and active dwell=fire=0 (all channels disabled).
REQ-019 rst asserted mid-dwell SHALL drop ign to 0 on the next cycle with no spark-timing guarantee.

Configuration
REQ-020 Macro IGN_DWELL_LIMIT_EN defined: per-channel cycle counter in DWELL; when it reaches MAX_DWELL_CYC, the channel SHALL go to LOCKOUT (ign=0), set fault[ch]; LOCKOUT->IDLE on the next angle==0 angle_valid; fault clears only on rst.
REQ-021 Macro undefined: no counter, LOCKOUT unreachable, fault tied to 0.

Structure
REQ-022 Package efi_pkg SHALL hold ANGLE_W, ANGLE_MAX, N_CH defaults and the channel state encoding.
REQ-023 Sub-module ign_channel SHALL implement one channel (state machine, fire latch, dwell counter), instantiated N_CH times; config registers and commit logic stay in ign_scheduler.

Verification
REQ-024 Ch0 dwell=100, fire=140, commit, sweep angle 0..2879 synced -> ign[0] high from cycle after angle 100 to cycle after angle 140, once per cycle.
REQ-025 Ch1 dwell=2860, fire=20 (wraps) -> ign[1] high across the 2879->0 boundary, low after angle 20.
REQ-026 During ch0 dwell at angle 120, write fire=200 and commit -> spark still at 140; commit_pending=1 until angle 0; next cycle sparks at 200.
REQ-027 Drop synced at angle 120 with ch0 dwelling -> ign[0]=0 next cycle; no dwell restarts until synced=1 and angle 100 recurs.
REQ-028 IGN_DWELL_LIMIT_EN, stall angle_valid for 20000 cycles in dwell -> ign[0]=0, fault[0]=1, LOCKOUT until angle 0; without macro ign[0] stays 1, fault=0.
REQ-029 Ch2 dwell=fire=500 -> ign[2] stays 0 through a full sweep.

Source files
------------

// File: rtl/efi_pkg.sv
// Shared constants and channel state encoding for the ignition scheduler.
// Latency: n/a (package only). Backpressure: n/a.
// Contents: default N_CH / ANGLE_W / ANGLE_MAX / MAX_DWELL_CYC and ch_state_t.
package efi_pkg;

  localparam int N_CH          = 4;
  localparam int ANGLE_W       = 12;
  localparam int ANGLE_MAX     = 2880;   // 720 deg at 0.25 deg/count
  localparam int MAX_DWELL_CYC = 20000;  // 10 ms at 2 MHz

  typedef enum logic [1:0] {
    CH_IDLE    = 2'd0,
    CH_DWELL   = 2'd1,
    CH_LOCKOUT = 2'd2
  } ch_state_t;

endpackage

// File: rtl/ign_channel.sv
// One ignition channel: waits for its dwell angle, drives the coil, sparks at the latched fire angle.
// Latency: ign changes one clk after the qualifying angle_valid cycle. Backpressure: none.
// Ports: clk, rst (sync, active-high), synced, angle, angle_valid, dwell_angle/fire_angle (active
// config from the scheduler) -> ign (registered coil drive), fault (sticky dwell timeout).
// Optional macro IGN_DWELL_LIMIT_EN adds the dwell-time limit and LOCKOUT state.
module ign_channel #(
  parameter int ANGLE_W = efi_pkg::ANGLE_W
`ifdef IGN_DWELL_LIMIT_EN
  , parameter int MAX_DWELL_CYC = efi_pkg::MAX_DWELL_CYC
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               synced,
  input  logic [ANGLE_W-1:0] angle,
  input  logic               angle_valid,
  input  logic [ANGLE_W-1:0] dwell_angle,
  input  logic [ANGLE_W-1:0] fire_angle,
  output logic               ign,
  output logic               fault
);
  import efi_pkg::*;

  ch_state_t          state_q, state_d;
  logic [ANGLE_W-1:0] fire_q, fire_d;
  logic               ign_q;
  logic               dwell_hit;
  logic               fire_hit;

  assign dwell_hit = angle_valid && (angle == dwell_angle);
  // Spark compares against the angle captured at dwell start, so a commit mid-dwell
  // cannot move the spark of the event already in progress.
  assign fire_hit  = angle_valid && (angle == fire_q);

`ifdef IGN_DWELL_LIMIT_EN
  localparam int CNT_W = $clog2(MAX_DWELL_CYC + 1);

  logic [CNT_W-1:0] cnt_q;
  logic             timeout;
  logic             wrap;
  logic             fault_q;

  // Counter holds the number of completed DWELL cycles; the MAX_DWELL_CYC-th DWELL
  // cycle is therefore the last one with the coil on.
  assign timeout = (cnt_q == CNT_W'(MAX_DWELL_CYC - 1));
  assign wrap    = angle_valid && (angle == '0);
`endif

  always_comb begin
    state_d = state_q;
    fire_d  = fire_q;
    if (!synced) begin
      state_d = CH_IDLE;
    end else begin
      case (state_q)
        CH_IDLE: begin
          // Equal dwell and fire angles mean the channel is disabled.
          if (dwell_hit && (dwell_angle != fire_angle)) begin
            state_d = CH_DWELL;
            fire_d  = fire_angle;
          end
        end
        CH_DWELL: begin
          if (fire_hit) begin
            state_d = CH_IDLE;
          end
`ifdef IGN_DWELL_LIMIT_EN
          else if (timeout) begin
            state_d = CH_LOCKOUT;
          end
`endif
        end
        CH_LOCKOUT: begin
`ifdef IGN_DWELL_LIMIT_EN
          if (wrap) begin
            state_d = CH_IDLE;
          end
`else
          state_d = CH_IDLE;
`endif
        end
        default: state_d = CH_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CH_IDLE;
      fire_q  <= '0;
      ign_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fire_q  <= fire_d;
      ign_q   <= (state_d == CH_DWELL);
    end
  end

`ifdef IGN_DWELL_LIMIT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      if (state_q != CH_DWELL) begin
        cnt_q <= '0;
      end else if (!timeout) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if ((state_q == CH_DWELL) && (state_d == CH_LOCKOUT)) begin
        fault_q <= 1'b1;
      end
    end
  end

  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  assign ign = ign_q;

endmodule

// File: rtl/ign_scheduler.sv
// Angle-based ignition scheduler: shadow/active angle config with wrap-aligned commit, N_CH channels.
// Latency: ign one clk after the matching angle_valid; commit applies at the next angle-0 update.
// Backpressure: none; cfg writes always accepted, commit stays pending until the wrap.
// Ports: clk, rst (sync, active-high), synced, angle, angle_valid, cfg_we, cfg_addr {ch,sel},
// cfg_data, cfg_commit -> ign[N_CH], fault[N_CH], commit_pending.
// Optional macro IGN_DWELL_LIMIT_EN enables the per-channel dwell timeout and fault flags.
module ign_scheduler #(
  parameter int N_CH          = efi_pkg::N_CH,
  parameter int ANGLE_W       = efi_pkg::ANGLE_W,
  parameter int ANGLE_MAX     = efi_pkg::ANGLE_MAX,
  parameter int MAX_DWELL_CYC = efi_pkg::MAX_DWELL_CYC
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               synced,
  input  logic [ANGLE_W-1:0] angle,
  input  logic               angle_valid,
  input  logic               cfg_we,
  input  logic [2:0]         cfg_addr,
  input  logic [ANGLE_W-1:0] cfg_data,
  input  logic               cfg_commit,
  output logic [N_CH-1:0]    ign,
  output logic [N_CH-1:0]    fault,
  output logic               commit_pending
);
  import efi_pkg::*;

  // Elaboration-time sanity checks on the configuration.
  if (N_CH < 1 || N_CH > 4) begin : g_bad_nch
    $error("ign_scheduler: N_CH must be 1..4 (cfg_addr carries a 2-bit channel)");
  end
  if (ANGLE_MAX > (1 << ANGLE_W)) begin : g_bad_angle
    $error("ign_scheduler: ANGLE_MAX does not fit in ANGLE_W bits");
  end
  if (MAX_DWELL_CYC < 1) begin : g_bad_dwell
    $error("ign_scheduler: MAX_DWELL_CYC must be at least 1");
  end

  logic [ANGLE_W-1:0] dwell_sh  [N_CH];
  logic [ANGLE_W-1:0] fire_sh   [N_CH];
  logic [ANGLE_W-1:0] dwell_act [N_CH];
  logic [ANGLE_W-1:0] fire_act  [N_CH];
  logic               pending_q;
  logic               wrap;

  assign wrap = angle_valid && (angle == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < N_CH; c++) begin
        dwell_sh[c]  <= '0;
        fire_sh[c]   <= '0;
        dwell_act[c] <= '0;
        fire_act[c]  <= '0;
      end
      pending_q <= 1'b0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (cfg_we && (cfg_addr[2:1] == 2'(c))) begin
          if (cfg_addr[0]) fire_sh[c]  <= cfg_data;
          else             dwell_sh[c] <= cfg_data;
        end
      end
      // A commit landing on the wrap cycle itself is deferred to the following wrap,
      // so software never races the copy.
      if (cfg_commit) begin
        pending_q <= 1'b1;
      end else if (wrap && pending_q) begin
        pending_q <= 1'b0;
        for (int c = 0; c < N_CH; c++) begin
          dwell_act[c] <= dwell_sh[c];
          fire_act[c]  <= fire_sh[c];
        end
      end
    end
  end

  assign commit_pending = pending_q;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    ign_channel #(
      .ANGLE_W       (ANGLE_W)
`ifdef IGN_DWELL_LIMIT_EN
      , .MAX_DWELL_CYC (MAX_DWELL_CYC)
`endif
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .synced      (synced),
      .angle       (angle),
      .angle_valid (angle_valid),
      .dwell_angle (dwell_act[g]),
      .fire_angle  (fire_act[g]),
      .ign         (ign[g]),
      .fault       (fault[g])
    );
  end

endmodule
